// File: rtl/game_over_banner_ctrl.sv
// End-of-game "WINNER Pn" banner sequencer: latches the winner, slides the banner
// down to its resting row one step per frame, blinks it, and issues a restart pulse.
module game_over_banner_ctrl #(
    parameter int posBits         = 9,
    parameter int CENTER_X        = 124,
    parameter int START_Y         = 0,
    parameter int TARGET_Y        = 116,
    parameter int SLIDE_STEP      = 4,
    parameter int BLINK_FRAMES    = 30,
    parameter int MIN_HOLD_FRAMES = 120
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               game_over,
    input  logic               winner,
    input  logic               start,
    input  logic               collision,
    output logic [posBits-1:0] posX,
    output logic [posBits-1:0] posY,
    output logic               player,
    output logic               pixel_on,
    output logic               banner_en,
    output logic               restart
);

    localparam int HOLD_W  = $clog2(MIN_HOLD_FRAMES + 1);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [posBits-1:0] START_P  = posBits'(START_Y);
    localparam logic [posBits-1:0] TARGET_P = posBits'(TARGET_Y);
    localparam logic [posBits:0]   TARGET_W = (posBits + 1)'(TARGET_Y);
    localparam logic [posBits:0]   STEP_W   = (posBits + 1)'(SLIDE_STEP);
    localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(MIN_HOLD_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_TOP = BLINK_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SLIDE, HOLD, RESTART} state_t;

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               start_q;

    logic [posBits:0]   pos_sum;
    logic [posBits-1:0] pos_next;
    logic               start_edge;

    // One extra bit on the sum so a large step near the bottom clamps instead of wrapping.
    assign pos_sum    = {1'b0, posY} + STEP_W;
    assign pos_next   = (pos_sum >= TARGET_W) ? TARGET_P : pos_sum[posBits-1:0];
    assign start_edge = start & ~start_q;

    assign posX     = posBits'(CENTER_X);
    assign pixel_on = banner_en & collision;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            posY      <= START_P;
            player    <= 1'b0;
            banner_en <= 1'b0;
            restart   <= 1'b0;
            start_q   <= 1'b0;
            hold_cnt  <= '0;
            blink_cnt <= '0;
        end else begin
            start_q <= start;
            // NOTE: non-blocking default; the HOLD branch overrides it for the one pulse cycle.
            restart <= 1'b0;

            unique case (state)
                IDLE: begin
                    banner_en <= 1'b0;
                    posY      <= START_P;
                    hold_cnt  <= '0;
                    blink_cnt <= '0;
                    if (game_over) begin
                        state     <= SLIDE;
                        player    <= winner;
                        banner_en <= 1'b1;
                    end
                end

                SLIDE: begin
                    if (frame_tick) begin
                        posY <= pos_next;
                        if (pos_next == TARGET_P) begin
                            state     <= HOLD;
                            hold_cnt  <= '0;
                            blink_cnt <= '0;
                        end
                    end
                end

                HOLD: begin
                    // Only a saturated, already-registered hold count lets a press through.
                    if (start_edge && hold_cnt == HOLD_MAX) begin
                        state     <= RESTART;
                        restart   <= 1'b1;
                        banner_en <= 1'b0;
                    end else if (frame_tick) begin
                        if (hold_cnt != HOLD_MAX)
                            hold_cnt <= hold_cnt + 1'b1;
                        if (blink_cnt == BLINK_TOP) begin
                            blink_cnt <= '0;
                            banner_en <= ~banner_en;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end

                RESTART: begin
                    state     <= IDLE;
                    banner_en <= 1'b0;
                    posY      <= START_P;
                    hold_cnt  <= '0;
                    blink_cnt <= '0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/game_over_banner_ctrl.md
# game_over_banner_ctrl

Sequencer that drives the end-of-game "WINNER Pn" text renderer. On a game-over strobe it latches the winning player and slides the banner from the top of the screen to its resting row, one step per frame. It then blinks the banner and waits for a debounced start press to issue a one-cycle restart pulse to the game logic. It sits between the game state logic and the text renderer: it supplies the renderer's banner position and player-select inputs, and gates the renderer's per-pixel hit into the final pixel mux.

## Interface
- posBits, 9, width of position/coordinate buses
- CENTER_X, 124, fixed banner X origin (72-px-wide banner centred on 320)
- START_Y, 0, banner Y origin at slide start
- TARGET_Y, 116, banner Y resting row
- SLIDE_STEP, 4, Y increment per frame during slide
- BLINK_FRAMES, 30, frames per blink half-period
- MIN_HOLD_FRAMES, 120, frames after arrival before start is accepted

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame (vsync-derived)
- game_over  in  1  level/strobe from game logic; sampled only in IDLE
- winner  in  1  1 = player 1 won, 0 = player 2; sampled with game_over
- start  in  1  debounced start button level
- collision  in  1  renderer hit for the current pixel
- posX  out  posBits  banner X origin to renderer
- posY  out  posBits  banner Y origin to renderer
- player  out  1  latched winner to renderer
- pixel_on  out  1  banner_en & collision (combinational)
- banner_en  out  1  banner visible
- restart  out  1  one-cycle restart request to game logic

## Operation
- States: IDLE, SLIDE, HOLD, RESTART.
- IDLE: banner_en=0, posY=START_Y, frame counters cleared. game_over=1 → SLIDE next cycle; player ← winner on the same edge.
- SLIDE: banner_en=1. On each frame_tick: posY ← min(posY+SLIDE_STEP, TARGET_Y), with the sum computed at posBits+1 bits (no wrap). When the updated posY equals TARGET_Y → HOLD, with blink and hold counters at 0.
- HOLD: on each frame_tick the hold counter increments, saturating at MIN_HOLD_FRAMES, and the blink counter increments. When the blink counter reaches BLINK_FRAMES-1 it clears and banner_en toggles. Entry value is banner_en=1.
- Start edge: start_q registers start every cycle; edge = start & ~start_q. In HOLD with hold counter == MIN_HOLD_FRAMES, edge → RESTART. An edge before that is discarded. A held start never retriggers.
- RESTART: restart=1 and banner_en=0 for exactly one cycle, then IDLE.
- player holds its value until the next IDLE→SLIDE transition.
- game_over and winner are ignored outside IDLE.
- posX = CENTER_X constant.
- pixel_on = banner_en & collision, with no registering.

## Timing
- Reset values: state IDLE, posX=CENTER_X, posY=START_Y, player=0, banner_en=0, restart=0, start_q=0, counters 0.
- game_over sampled at edge N → banner_en=1 and player valid after edge N.
- posY updates on the edge where frame_tick=1. Frames with no tick leave all positions unchanged.
- With defaults, the slide takes 29 ticks (0→116).
- frame_tick and start edge in the same cycle in HOLD with hold satisfied → RESTART; the tick's counter update is don't-care.
- Start edge on the cycle the hold counter reaches MIN_HOLD_FRAMES is not accepted. Acceptance requires the saturated value already registered.
- restart asserted the cycle after the accepted edge, for 1 cycle. The state is IDLE the following cycle.
- game_over held high through RESTART → re-enters SLIDE one cycle after IDLE is reached.
- reset asserted in any state → reset values on the next edge. A restart pulse in flight is cancelled.

## Test plan
- Reset, then game_over=1 and winner=1 for 1 cycle → next cycle banner_en=1, player=1, posY=0. After 29 frame_ticks, posY=116 and state HOLD.
- SLIDE_STEP=5 → posY sequence 0,5,…,115,116. Clamps after 24 ticks and never exceeds 116.
- In HOLD, 60 frame_ticks → banner_en toggles at ticks 30 and 60 (1→0→1). pixel_on follows collision only while banner_en=1.
- start pulse at hold tick 50 → no restart. start pulse after tick 120 → restart high for exactly 1 cycle, then banner_en=0 and posY=0. start held high through tick 120 → no restart until released and re-pressed.
- game_over=1 and winner=0 while in HOLD → player unchanged and state unchanged.
- reset asserted mid-SLIDE at posY=40 → next cycle all outputs at reset values. A subsequent game_over restarts the slide from posY=0.
